// File: rtl/machine_pkg.sv
// Shared front-panel constants for the Machine CPU step and its input conditioner.
// The CPU decodes panel_word using the same field positions.
package machine_pkg;

    localparam int PANEL_SW_W   = 8;
    localparam int PANEL_BTN_W  = 4;
    localparam int PANEL_WORD_W = PANEL_SW_W + PANEL_BTN_W;
    localparam int PANEL_SW_LSB  = 4;
    localparam int PANEL_BTN_LSB = 0;
    localparam int BTN_WRITE     = 0;

    typedef struct packed {
        logic [PANEL_SW_W-1:0]  sw;
        logic [PANEL_BTN_W-1:0] btn;
    } panel_word_t;

    function automatic logic [PANEL_WORD_W-1:0] pack_panel(
        input logic [PANEL_SW_W-1:0]  sw,
        input logic [PANEL_BTN_W-1:0] btn
    );
        panel_word_t pw;
        pw.sw  = sw;
        pw.btn = btn;
        return pw;
    endfunction

endpackage

// File: rtl/machine_debounce_bit.sv
// One panel bit: synchroniser chain, optional inversion, debounce counter, stable reg.
// The stable level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
module machine_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter bit SYNC_RST        = 1'b0,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{SYNC_RST}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Inversion sits after the last stage so the reset level reads as released.
    assign synced = sync_q[SYNC_STAGES-1] ^ INVERT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (synced == stable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            stable <= synced;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/machine_panel_input.sv
// Front-panel conditioner: debounced switches plus one-shot button pulses,
// packed into the 12-bit CPU input word {sw_stable, btn_pulse}.
module machine_panel_input
    import machine_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    input  logic [PANEL_SW_W-1:0]   sw_raw,
    input  logic [PANEL_BTN_W-1:0]  btn_raw,
    output logic [PANEL_SW_W-1:0]   sw_stable,
    output logic [PANEL_BTN_W-1:0]  btn_level,
    output logic [PANEL_BTN_W-1:0]  btn_pulse,
    output logic [PANEL_WORD_W-1:0] panel_word
);

    logic [PANEL_WORD_W-1:0] raw_word;
    logic [PANEL_WORD_W-1:0] stable_word;
    logic [PANEL_BTN_W-1:0]  level_d;

    assign raw_word = pack_panel(sw_raw, btn_raw);

    for (genvar i = 0; i < PANEL_WORD_W; i++) begin : g_bit
        localparam bit IS_BTN = (i < PANEL_SW_LSB);
        localparam bit INV    = IS_BTN && (BTN_ACTIVE_LOW != 0);

        machine_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_RST        (INV),
            .INVERT          (INV)
        ) u_bit (
            .clk    (system1000),
            .rst_n  (system1000_rstn),
            .raw    (raw_word[i]),
            .stable (stable_word[i])
        );
    end

    assign sw_stable = stable_word[PANEL_SW_LSB +: PANEL_SW_W];
    assign btn_level = stable_word[PANEL_BTN_LSB +: PANEL_BTN_W];

    // Rising edge of the debounced level only: no pulse on release or hold.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            level_d   <= '0;
            btn_pulse <= '0;
        end else begin
            level_d   <= btn_level;
            btn_pulse <= btn_level & ~level_d;
        end
    end

    assign panel_word = pack_panel(sw_stable, btn_pulse);

endmodule

// File: tb/tb_machine_panel_input.sv
// Self-checking bench: directed table, corner sequences and random stimulus
// against a sample-window reference model.
module tb_machine_panel_input;

    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  sw_raw = 8'h00;
    logic [3:0]  btn_raw = 4'hF;
    logic [7:0]  sw_stable;
    logic [3:0]  btn_level;
    logic [3:0]  btn_pulse;
    logic [11:0] panel_word;

    int errors = 0;
    int checks = 0;

    machine_panel_input #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (16),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .sw_raw          (sw_raw),
        .btn_raw         (btn_raw),
        .sw_stable       (sw_stable),
        .btn_level       (btn_level),
        .btn_pulse       (btn_pulse),
        .panel_word      (panel_word)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Reference: sample pipeline, window of the last D samples, level history.
    logic [11:0] m_sync [S];
    logic [11:0] m_hist [D];
    logic [11:0] m_stable;
    logic [11:0] m_stable_d;
    logic [3:0]  m_pulse;

    task automatic model_reset();
        for (int i = 0; i < S; i++) m_sync[i] = '0;
        for (int i = 0; i < D; i++) m_hist[i] = '0;
        m_stable   = '0;
        m_stable_d = '0;
        m_pulse    = '0;
    endtask

    task automatic model_step();
        logic [11:0] cur;
        logic [11:0] nstab;
        logic        all_diff;
        cur = m_sync[S-1];
        for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = cur;
        nstab = m_stable;
        for (int b = 0; b < 12; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++)
                if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nstab[b] = ~m_stable[b];
        end
        m_pulse    = m_stable[3:0] & ~m_stable_d[3:0];
        m_stable_d = m_stable;
        m_stable   = nstab;
        for (int k = S - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = {sw_raw, ~btn_raw};
    endtask

    task automatic chk(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("model_sw", 12'(sw_stable), 12'(m_stable[11:4]));
        chk("model_lvl", 12'(btn_level), 12'(m_stable[3:0]));
        chk("model_pls", 12'(btn_pulse), 12'(m_pulse));
        chk("model_word", panel_word, {m_stable[11:4], m_pulse});
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rstn) model_step();
        @(negedge clk);
        chk_model();
    endtask

    task automatic chk_zero(input string name);
        chk(name, {sw_stable, btn_level}, 12'h000);
        chk(name, 12'(btn_pulse), 12'h000);
        chk(name, panel_word, 12'h000);
    endtask

    typedef struct {
        logic       rstn;
        logic [7:0] sw;
        logic [3:0] btn;
        logic [7:0] e_sw;
        logic [3:0] e_lvl;
        logic [3:0] e_pls;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [7:0] s, logic [3:0] b,
                                logic [7:0] es, logic [3:0] el,
                                logic [3:0] ep);
        vec_t v;
        v.rstn = r; v.sw = s; v.btn = b;
        v.e_sw = es; v.e_lvl = el; v.e_pls = ep;
        return v;
    endfunction

    initial begin
        int pc;
        logic seen;
        int r;

        model_reset();

        // Reset with A5 on the switches, release, then press btn0 for 20 cycles.
        tbl.push_back(mk(1'b0, 8'hA5, 4'hF, 8'h00, 4'h0, 4'h0));
        tbl.push_back(mk(1'b0, 8'hA5, 4'hF, 8'h00, 4'h0, 4'h0));
        for (int n = 1; n <= 8; n++)
            tbl.push_back(mk(1'b1, 8'hA5, 4'hF,
                             (n >= 6) ? 8'hA5 : 8'h00, 4'h0, 4'h0));
        for (int n = 1; n <= 20; n++)
            tbl.push_back(mk(1'b1, 8'hA5, 4'hE, 8'hA5,
                             (n >= 6) ? 4'h1 : 4'h0,
                             (n == 7) ? 4'h1 : 4'h0));
        for (int n = 1; n <= 12; n++)
            tbl.push_back(mk(1'b1, 8'hA5, 4'hF, 8'hA5,
                             (n < 6) ? 4'h1 : 4'h0, 4'h0));

        @(negedge clk);
        foreach (tbl[i]) begin
            rstn    = tbl[i].rstn;
            sw_raw  = tbl[i].sw;
            btn_raw = tbl[i].btn;
            if (!rstn) model_reset();
            cyc();
            chk("tbl_sw", 12'(sw_stable), 12'(tbl[i].e_sw));
            chk("tbl_lvl", 12'(btn_level), 12'(tbl[i].e_lvl));
            chk("tbl_pls", 12'(btn_pulse), 12'(tbl[i].e_pls));
            chk("tbl_word", panel_word, {tbl[i].e_sw, tbl[i].e_pls});
        end

        // btn1 bounce 0,1,0,1 then held low.
        pc = 0;
        btn_raw = 4'hD; cyc(); pc += int'(btn_pulse[1]);
        btn_raw = 4'hF; cyc(); pc += int'(btn_pulse[1]);
        btn_raw = 4'hD; cyc(); pc += int'(btn_pulse[1]);
        btn_raw = 4'hF; cyc(); pc += int'(btn_pulse[1]);
        btn_raw = 4'hD;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            if (n == 7) chk("t3_pulse_at7", 12'(btn_pulse), 12'h002);
            pc += int'(btn_pulse[1]);
        end
        chk("t3_one_pulse", 12'(pc), 12'd1);
        btn_raw = 4'hF;
        repeat (10) cyc();

        // btn2 low for only 3 cycles must be rejected.
        seen = 1'b0;
        btn_raw = 4'hB;
        repeat (3) begin
            cyc();
            seen |= btn_level[2] | btn_pulse[2];
        end
        btn_raw = 4'hF;
        repeat (12) begin
            cyc();
            seen |= btn_level[2] | btn_pulse[2];
        end
        chk("t4_glitch_rejected", 12'(seen), 12'h000);

        // All four buttons pressed together, then released.
        btn_raw = 4'h0;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            if (n == 7) chk("t5_all_pulse", 12'(btn_pulse), 12'h00F);
            if (n == 8) chk("t5_pulse_1cyc", 12'(btn_pulse), 12'h000);
        end
        pc = 0;
        btn_raw = 4'hF;
        repeat (15) begin
            cyc();
            pc += int'(btn_pulse != 4'h0);
        end
        chk("t5_no_release_pulse", 12'(pc), 12'd0);
        chk("t5_released", 12'(btn_level), 12'h000);

        // Reset mid-count with btn0 held through reset.
        btn_raw = 4'hE;
        repeat (4) cyc();
        rstn = 1'b0;
        model_reset();
        #1;
        chk_zero("t6_reset_clear");
        cyc();
        cyc();
        rstn = 1'b1;
        pc = 0;
        for (int n = 1; n <= 15; n++) begin
            cyc();
            if (n == 7) chk("t6_pulse_at7", 12'(btn_pulse), 12'h001);
            pc += int'(btn_pulse[0]);
        end
        chk("t6_one_pulse", 12'(pc), 12'd1);
        btn_raw = 4'hF;
        repeat (10) cyc();

        // Random toggles, glitches and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rstn = 1'b0;
                model_reset();
                cyc();
                cyc();
                rstn = 1'b1;
            end
            r = int'($urandom_range(0, 15));
            if (r == 0) sw_raw ^= 8'(1 << $urandom_range(0, 7));
            if (r < 3)  btn_raw ^= 4'(1 << $urandom_range(0, 3));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
